// File: rtl/aurora_hls_monitor_regs.sv
// AXI4-Lite register front-end for the Aurora link monitor counter bank.
// Holds a coherent shadow snapshot of all monitor counters, two 16-bit event
// sequence numbers, and drives a one-cycle clear pulse back to the monitor.
module aurora_hls_monitor_regs #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NUM_COUNTERS = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [32*NUM_COUNTERS-1:0]   counters,
    output logic                         counter_clear,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SH_W   = $clog2(NUM_COUNTERS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t              r_wstate;
    r_state_t              r_rstate;
    logic                  r_live;
    logic [DATA_W-1:0]     r_shadow [NUM_COUNTERS];
    logic [SEQ_W-1:0]      r_snap_seq;
    logic [SEQ_W-1:0]      r_clr_seq;
    logic                  r_clear;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_wr_accept;
    logic                  w_wr_ctrl;
    logic                  w_rd_accept;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_W-1:0]     w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    // Address bits below word granularity and unused data/strobe bits are ignored.
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:2], s_axi_wstrb[3:1]};

    // AW and W are only taken together; readies stay low until the first edge out of reset.
    assign w_wr_accept   = r_live && (r_wstate == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = w_wr_accept;
    assign s_axi_wready  = w_wr_accept;
    assign w_wr_ctrl     = (s_axi_awaddr[7:2] == IDX_W'(0));

    assign s_axi_arready = r_live && (r_rstate == R_IDLE);
    assign w_rd_accept   = s_axi_arready && s_axi_arvalid;
    assign w_rd_idx      = s_axi_araddr[7:2];

    assign counter_clear = r_clear;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    // Gate the handshakes off while reset is held and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // Read address decode: CTRL word, shadow bank, or SLVERR for anything else.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_rd_idx == IDX_W'(0)) begin
            w_rd_data = {r_snap_seq, r_clr_seq};
        end else if (w_rd_idx <= IDX_W'(NUM_COUNTERS)) begin
            w_rd_data = r_shadow[SH_W'(w_rd_idx - IDX_W'(1))];
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    // Write FSM plus CTRL side effects: atomic snapshot and single-cycle clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate   <= W_IDLE;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_clear    <= 1'b0;
            r_snap_seq <= '0;
            r_clr_seq  <= '0;
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) r_shadow[i] <= '0;
        end else begin
            r_clear <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_accept) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_ctrl ? RESP_OKAY : RESP_SLVERR;
                        if (w_wr_ctrl && s_axi_wstrb[0]) begin
                            if (s_axi_wdata[0]) begin
                                for (int unsigned i = 0; i < NUM_COUNTERS; i++)
                                    r_shadow[i] <= counters[DATA_W*i +: DATA_W];
                                r_snap_seq <= r_snap_seq + SEQ_W'(1);
                            end
                            if (s_axi_wdata[1]) begin
                                r_clear   <= 1'b1;
                                r_clr_seq <= r_clr_seq + SEQ_W'(1);
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate <= W_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: register decoded data at AR acceptance and hold it until R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_accept) begin
                        r_rstate <= R_DATA;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_rd_data;
                        r_rresp  <= w_rd_resp;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rstate <= R_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule
